dom_sbox_sequencer: RTL

- Sequences a 2-share DOM-masked 16-bit SSAES state through one shared, pipelined masked GF(2^4) S-box core, one nibble per advance.
- Owns the S-box pipeline enable and the fresh-randomness handshake to the PRNG.
- Gathers the substituted nibbles back into a 2-share state.
- Sits between the round controller (state in/out handshake) and the masked S-box core.

---
 rtl/ssaes_pkg.sv | 17 +
 rtl/ssaes_nibble_collector.sv | 73 +++++++
 rtl/dom_sbox_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/ssaes_pkg.sv
// Shared constants and FSM state type for the masked SSAES S-box datapath.
package ssaes_pkg;

    localparam int NIBBLE_W           = 4;
    localparam int SHARES             = 2;
    localparam int DOM_RND_PER_GADGET = SHARES * (SHARES - 1);
    localparam int DOM_GADGETS        = 3;
    localparam int RND_W_DEF          = DOM_GADGETS * DOM_RND_PER_GADGET;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } seq_state_e;

endpackage

// File: rtl/ssaes_nibble_collector.sv
// Per-share result capture: tracks S-box pipeline occupancy and writes each
// emerging nibble into separate share A / share B result registers.
module ssaes_nibble_collector
    import ssaes_pkg::*;
#(
    parameter int NIBBLES  = 4,
    parameter int SBOX_LAT = 2,
    parameter int CNT_W    = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear_i,
    input  logic                         advance_i,
    input  logic                         valid_in_i,
    input  logic [NIBBLE_W-1:0]          sbox_a_i,
    input  logic [NIBBLE_W-1:0]          sbox_b_i,
    output logic [NIBBLES*NIBBLE_W-1:0]  out_a_o,
    output logic [NIBBLES*NIBBLE_W-1:0]  out_b_o,
    output logic                         last_capture_o
);

    localparam int              STATE_W  = NIBBLES * NIBBLE_W;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    logic [SBOX_LAT-1:0] vpipe_q, vpipe_d;
    logic [CNT_W-1:0]    collect_cnt_q, collect_cnt_d;
    logic [STATE_W-1:0]  cap_a_q, cap_a_d;
    logic [STATE_W-1:0]  cap_b_q, cap_b_d;
    logic                capture;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vpipe_q       <= '0;
            collect_cnt_q <= '0;
            cap_a_q       <= '0;
            cap_b_q       <= '0;
        end else begin
            vpipe_q       <= vpipe_d;
            collect_cnt_q <= collect_cnt_d;
            cap_a_q       <= cap_a_d;
            cap_b_q       <= cap_b_d;
        end
    end

    // The valid pipe mirrors the S-box register stages, so its tail marks a
    // real nibble at the S-box output on the same advance.
    always_comb begin
        vpipe_d       = vpipe_q;
        collect_cnt_d = collect_cnt_q;
        cap_a_d       = cap_a_q;
        cap_b_d       = cap_b_q;
        capture       = advance_i && vpipe_q[SBOX_LAT-1];

        if (clear_i) begin
            vpipe_d       = '0;
            collect_cnt_d = '0;
        end else if (advance_i) begin
            vpipe_d = (vpipe_q << 1) | SBOX_LAT'(valid_in_i);
            if (capture) begin
                cap_a_d[collect_cnt_q*NIBBLE_W +: NIBBLE_W] = sbox_a_i;
                cap_b_d[collect_cnt_q*NIBBLE_W +: NIBBLE_W] = sbox_b_i;
                if (collect_cnt_q != LAST_NIB) begin
                    collect_cnt_d = collect_cnt_q + 1'b1;
                end
            end
        end
    end

    assign last_capture_o = capture && (collect_cnt_q == LAST_NIB);
    assign out_a_o        = cap_a_q;
    assign out_b_o        = cap_b_q;

endmodule

// File: rtl/dom_sbox_sequencer.sv
// Streams a 2-share masked state nibble by nibble through one shared pipelined
// DOM S-box, gated by the fresh-randomness handshake, and reassembles the result.
module dom_sbox_sequencer
    import ssaes_pkg::*;
#(
    parameter int NIBBLES  = 4,
    parameter int SBOX_LAT = 2,
    parameter int RND_W    = RND_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NIBBLES*NIBBLE_W-1:0]  in_a,
    input  logic [NIBBLES*NIBBLE_W-1:0]  in_b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NIBBLES*NIBBLE_W-1:0]  out_a,
    output logic [NIBBLES*NIBBLE_W-1:0]  out_b,
    input  logic                         rnd_valid,
    output logic                         rnd_ready,
    input  logic [RND_W-1:0]             rnd_data,
    output logic                         sbox_en,
    output logic [NIBBLE_W-1:0]          sbox_a_in,
    output logic [NIBBLE_W-1:0]          sbox_b_in,
    output logic [RND_W-1:0]             sbox_z,
    input  logic [NIBBLE_W-1:0]          sbox_a_out,
    input  logic [NIBBLE_W-1:0]          sbox_b_out,
    output logic                         busy
);

    localparam int               CNT_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int               STATE_W  = NIBBLES * NIBBLE_W;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    seq_state_e         state_q, state_d;
    logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [STATE_W-1:0] a_q, a_d;
    logic [STATE_W-1:0] b_q, b_d;
    logic               advance;
    logic               accept;
    logic               feeding;
    logic               last_capture;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            issue_cnt_q <= '0;
            a_q         <= '0;
            b_q         <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        accept      = 1'b0;
        advance     = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        sbox_a_in   = '0;
        sbox_b_in   = '0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    accept      = 1'b1;
                    a_d         = in_a;
                    b_d         = in_b;
                    issue_cnt_d = '0;
                    state_d     = ST_FEED;
                end
            end
            ST_FEED: begin
                advance   = rnd_valid;
                sbox_a_in = a_q[issue_cnt_q*NIBBLE_W +: NIBBLE_W];
                sbox_b_in = b_q[issue_cnt_q*NIBBLE_W +: NIBBLE_W];
                if (rnd_valid) begin
                    if (issue_cnt_q == LAST_NIB) begin
                        state_d = ST_DRAIN;
                    end else begin
                        issue_cnt_d = issue_cnt_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                advance = rnd_valid;
                if (last_capture) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // One PRNG word per advance: the enable and the consume strobe are the same signal.
    assign feeding   = (state_q == ST_FEED);
    assign sbox_en   = advance;
    assign rnd_ready = advance;
    assign sbox_z    = rnd_data;

    ssaes_nibble_collector #(
        .NIBBLES  (NIBBLES),
        .SBOX_LAT (SBOX_LAT),
        .CNT_W    (CNT_W)
    ) u_collector (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear_i        (accept),
        .advance_i      (advance),
        .valid_in_i     (feeding),
        .sbox_a_i       (sbox_a_out),
        .sbox_b_i       (sbox_b_out),
        .out_a_o        (out_a),
        .out_b_o        (out_b),
        .last_capture_o (last_capture)
    );

endmodule
